// File: rtl/spi_mem_arbiter.sv
// Two-port transaction arbiter in front of spi_sram_master; grants whole transactions, bursts included.
// Define SPI_MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise port 0 has fixed priority.
module spi_mem_arbiter #(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic [AW-1:0] p0_addr,
  input  logic          p0_en,
  input  logic          p0_wr,
  input  logic          p0_rburst,
  input  logic          p0_wburst,
  input  logic [7:0]    p0_wdata,
  output logic          p0_rdy,
  output logic          p0_rdata_load,
  input  logic [AW-1:0] p1_addr,
  input  logic          p1_en,
  input  logic          p1_wr,
  input  logic          p1_rburst,
  input  logic          p1_wburst,
  input  logic [7:0]    p1_wdata,
  output logic          p1_rdy,
  output logic          p1_rdata_load,
  output logic [7:0]    p_rdata,
  output logic [7:0]    p_rdata0,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_wr,
  output logic          mem_rburst,
  output logic          mem_wburst,
  output logic [7:0]    mem_wdata,
  input  logic          mem_rdy,
  input  logic [7:0]    mem_rdata,
  input  logic [7:0]    mem_rdata0,
  input  logic          mem_rdata_load,
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       complete;
  logic       pick_p1;

`ifdef SPI_MEM_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign pick_p1 = ptr_q;
`else
  assign pick_p1 = 1'b0;
`endif

  // Downstream request mux driven only by the registered grant, so mem_rdy never reaches mem_en.
  always_comb begin
    mem_addr   = '0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_rburst = 1'b0;
    mem_wburst = 1'b0;
    mem_wdata  = '0;
    unique case (gnt_q)
      2'b01: begin
        mem_addr   = p0_addr;
        mem_en     = p0_en;
        mem_wr     = p0_wr;
        mem_rburst = p0_rburst;
        mem_wburst = p0_wburst;
        mem_wdata  = p0_wdata;
      end
      2'b10: begin
        mem_addr   = p1_addr;
        mem_en     = p1_en;
        mem_wr     = p1_wr;
        mem_rburst = p1_rburst;
        mem_wburst = p1_wburst;
        mem_wdata  = p1_wdata;
      end
      default: ;
    endcase
  end

  assign p0_rdy        = mem_rdy & gnt_q[0];
  assign p1_rdy        = mem_rdy & gnt_q[1];
  assign p0_rdata_load = mem_rdata_load & gnt_q[0];
  assign p1_rdata_load = mem_rdata_load & gnt_q[1];
  assign p_rdata       = mem_rdata;
  assign p_rdata0      = mem_rdata0;
  assign gnt           = gnt_q;

  assign complete = mem_en & mem_rdy & ~mem_rburst & ~mem_wburst;

  // Release on completion or abandon; the releasing port always yields to the other or goes idle.
  always_comb begin
    state_d = state_q;
`ifdef SPI_MEM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (p0_en && p1_en) state_d = pick_p1 ? G1 : G0;
        else if (p0_en)     state_d = G0;
        else if (p1_en)     state_d = G1;
      end
      G0: begin
        if (complete || !p0_en) begin
          state_d = p1_en ? G1 : IDLE;
`ifdef SPI_MEM_ARB_RR_EN
          ptr_d   = 1'b1;
`endif
        end
      end
      G1: begin
        if (complete || !p1_en) begin
          state_d = p0_en ? G0 : IDLE;
`ifdef SPI_MEM_ARB_RR_EN
          ptr_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = {state_d == G1, state_d == G0};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
`ifdef SPI_MEM_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
`ifdef SPI_MEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: reset, single read, burst handoff, simultaneous requests,
// same-port back-to-back, abandon and asynchronous reset mid-burst.
module tb_spi_mem_arbiter;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [AW-1:0] p0_addr, p1_addr;
  logic          p0_en, p0_wr, p0_rburst, p0_wburst;
  logic          p1_en, p1_wr, p1_rburst, p1_wburst;
  logic [7:0]    p0_wdata, p1_wdata;
  logic          p0_rdy, p0_rdata_load, p1_rdy, p1_rdata_load;
  logic [7:0]    p_rdata, p_rdata0;
  logic [AW-1:0] mem_addr;
  logic          mem_en, mem_wr, mem_rburst, mem_wburst;
  logic [7:0]    mem_wdata;
  logic          mem_rdy, mem_rdata_load;
  logic [7:0]    mem_rdata, mem_rdata0;
  logic [1:0]    gnt;

  int n_tests = 0;
  int n_fail  = 0;

  spi_mem_arbiter #(.AW(AW)) dut (
    .clk(clk), .arst_n(arst_n),
    .p0_addr(p0_addr), .p0_en(p0_en), .p0_wr(p0_wr), .p0_rburst(p0_rburst),
    .p0_wburst(p0_wburst), .p0_wdata(p0_wdata), .p0_rdy(p0_rdy), .p0_rdata_load(p0_rdata_load),
    .p1_addr(p1_addr), .p1_en(p1_en), .p1_wr(p1_wr), .p1_rburst(p1_rburst),
    .p1_wburst(p1_wburst), .p1_wdata(p1_wdata), .p1_rdy(p1_rdy), .p1_rdata_load(p1_rdata_load),
    .p_rdata(p_rdata), .p_rdata0(p_rdata0),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_rburst(mem_rburst),
    .mem_wburst(mem_wburst), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .mem_rdata0(mem_rdata0),
    .mem_rdata_load(mem_rdata_load), .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_addr = '0; p0_en = 0; p0_wr = 0; p0_rburst = 0; p0_wburst = 0; p0_wdata = '0;
    p1_addr = '0; p1_en = 0; p1_wr = 0; p1_rburst = 0; p1_wburst = 0; p1_wdata = '0;
    mem_rdy = 0; mem_rdata = '0; mem_rdata0 = '0; mem_rdata_load = 0;
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    arst_n  = 1'b0;
    mem_rdy = 1'b1;
    tick();
    n_tests++;
    if (gnt !== 2'b00 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: gnt=%b mem_en=%b expected 00/0", gnt, mem_en);
    end
    n_tests++;
    if (p0_rdy !== 1'b0 || p1_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy: p0_rdy=%b p1_rdy=%b expected 0/0", p0_rdy, p1_rdy);
    end
    mem_rdy = 1'b0;
    arst_n  = 1'b1;
    tick();
    n_tests++;
    if (gnt !== 2'b00 || mem_addr !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: gnt=%b mem_addr=%h expected 00/000000", gnt, mem_addr);
    end
  endtask

  task automatic test_single_read();
    p0_addr = 24'h000123; p0_en = 1; p0_wr = 0;
    #1;
    n_tests++;
    if (mem_en !== 1'b0 || gnt !== 2'b00) begin
      n_fail++; $display("FAIL idle_outputs_zero: mem_en=%b gnt=%b expected 0/00", mem_en, gnt);
    end
    tick();
    n_tests++;
    if (gnt !== 2'b01 || mem_en !== 1'b1 || mem_addr !== 24'h000123 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL p0_grant: gnt=%b mem_en=%b mem_addr=%h mem_wr=%b expected 01/1/000123/0",
                         gnt, mem_en, mem_addr, mem_wr);
    end
    mem_rdy = 1; mem_rdata = 8'hA5; mem_rdata_load = 1;
    #1;
    n_tests++;
    if (p0_rdy !== 1'b1 || p_rdata !== 8'hA5 || p1_rdy !== 1'b0 || p0_rdata_load !== 1'b1 ||
        p1_rdata_load !== 1'b0) begin
      n_fail++; $display("FAIL p0_read_beat: p0_rdy=%b p_rdata=%h p1_rdy=%b p0_load=%b p1_load=%b expected 1/a5/0/1/0",
                         p0_rdy, p_rdata, p1_rdy, p0_rdata_load, p1_rdata_load);
    end
    tick();
    mem_rdy = 0; mem_rdata_load = 0; p0_en = 0;
    #1;
    n_tests++;
    if (gnt !== 2'b00 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL p0_release: gnt=%b mem_en=%b expected 00/0", gnt, mem_en);
    end
    tick();
  endtask

  task automatic test_burst_handoff();
    p1_addr = 24'h010000; p1_en = 1; p1_wr = 1; p1_wburst = 1; p1_wdata = 8'h3C;
    tick();
    n_tests++;
    if (gnt !== 2'b10 || mem_addr !== 24'h010000 || mem_wr !== 1'b1 || mem_wburst !== 1'b1 ||
        mem_wdata !== 8'h3C) begin
      n_fail++; $display("FAIL p1_grant: gnt=%b addr=%h wr=%b wburst=%b wdata=%h expected 10/010000/1/1/3c",
                         gnt, mem_addr, mem_wr, mem_wburst, mem_wdata);
    end
    for (int beat = 1; beat <= 4; beat++) begin
      if (beat == 4) p1_wburst = 0;
      mem_rdy = 1;
      #1;
      n_tests++;
      if (p1_rdy !== 1'b1 || p0_rdy !== 1'b0) begin
        n_fail++; $display("FAIL burst_beat%0d_rdy: p1_rdy=%b p0_rdy=%b expected 1/0", beat, p1_rdy, p0_rdy);
      end
      tick();
      mem_rdy = 0;
      if (beat == 1) begin
        p0_addr = 24'h000456; p0_en = 1; p0_wr = 0;
      end
      if (beat < 4) begin
        #1;
        n_tests++;
        if (gnt !== 2'b10 || mem_addr !== 24'h010000) begin
          n_fail++; $display("FAIL burst_hold%0d: gnt=%b mem_addr=%h expected 10/010000", beat, gnt, mem_addr);
        end
        tick();
      end
    end
    p1_en = 0; p1_wr = 0;
    #1;
    n_tests++;
    if (gnt !== 2'b01 || mem_en !== 1'b1 || mem_addr !== 24'h000456 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL handoff_to_p0: gnt=%b mem_en=%b mem_addr=%h mem_wr=%b expected 01/1/000456/0",
                         gnt, mem_en, mem_addr, mem_wr);
    end
    mem_rdy = 1;
    tick();
    mem_rdy = 0; p0_en = 0;
    #1;
    n_tests++;
    if (gnt !== 2'b00) begin
      n_fail++; $display("FAIL handoff_release: gnt=%b expected 00", gnt);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [1:0] want;
    pulse_reset();
    for (int r = 0; r < 4; r++) begin
`ifdef SPI_MEM_ARB_RR_EN
      want = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
      want = 2'b01;
`endif
      p0_addr = 24'h000100 + 24'(r); p0_en = 1;
      p1_addr = 24'h020000 + 24'(r); p1_en = 1;
      tick();
      n_tests++;
      if (gnt !== want) begin
        n_fail++; $display("FAIL simul_round%0d: gnt=%b expected %b", r, gnt, want);
      end
      if (want == 2'b01) p1_en = 0;
      else               p0_en = 0;
      mem_rdy = 1;
      #1;
      n_tests++;
      if (p0_rdy !== want[0] || p1_rdy !== want[1]) begin
        n_fail++; $display("FAIL simul_rdy%0d: p0_rdy=%b p1_rdy=%b expected %b/%b",
                           r, p0_rdy, p1_rdy, want[0], want[1]);
      end
      tick();
      mem_rdy = 0; p0_en = 0; p1_en = 0;
      #1;
      n_tests++;
      if (gnt !== 2'b00) begin
        n_fail++; $display("FAIL simul_release%0d: gnt=%b expected 00", r, gnt);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    p0_addr = 24'h000777; p0_en = 1;
    tick();
    mem_rdy = 1;
    tick();
    mem_rdy = 0;
    p0_addr = 24'h000778;
    #1;
    n_tests++;
    if (gnt !== 2'b00 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_gap: gnt=%b mem_en=%b expected 00/0", gnt, mem_en);
    end
    tick();
    n_tests++;
    if (gnt !== 2'b01 || mem_addr !== 24'h000778) begin
      n_fail++; $display("FAIL b2b_regrant: gnt=%b mem_addr=%h expected 01/000778", gnt, mem_addr);
    end
    mem_rdy = 1;
    tick();
    mem_rdy = 0; p0_en = 0;
    tick();
  endtask

  task automatic test_abandon();
    p1_addr = 24'h030000; p1_en = 1; p1_rburst = 1;
    tick();
    mem_rdy = 1;
    tick();
    mem_rdy = 0;
    #1;
    n_tests++;
    if (gnt !== 2'b10) begin
      n_fail++; $display("FAIL rburst_hold: gnt=%b expected 10", gnt);
    end
    p1_en = 0; p1_rburst = 0;
    tick();
    n_tests++;
    if (gnt !== 2'b00 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL abandon_release: gnt=%b mem_en=%b expected 00/0", gnt, mem_en);
    end
  endtask

  task automatic test_async_reset();
    p0_addr = 24'h000010; p0_en = 1;
    tick();
    mem_rdy = 1;
    tick();
    mem_rdy = 0; p0_en = 0;
    p1_addr = 24'h040000; p1_en = 1; p1_rburst = 1;
    tick();
    tick();
    mem_rdy = 1;
    tick();
    mem_rdy = 0;
    #1;
    n_tests++;
    if (gnt !== 2'b10 || mem_en !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_g1: gnt=%b mem_en=%b expected 10/1", gnt, mem_en);
    end
    arst_n = 1'b0;
    #1;
    n_tests++;
    if (gnt !== 2'b00 || mem_en !== 1'b0 || p1_rdy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: gnt=%b mem_en=%b p1_rdy=%b expected 00/0/0", gnt, mem_en, p1_rdy);
    end
    p1_rburst = 0;
    p0_addr = 24'h000020; p0_en = 1;
    tick();
    arst_n = 1'b1;
    tick();
    n_tests++;
    if (gnt !== 2'b01 || mem_addr !== 24'h000020) begin
      n_fail++; $display("FAIL post_reset_priority: gnt=%b mem_addr=%h expected 01/000020", gnt, mem_addr);
    end
    mem_rdy = 1;
    tick();
    mem_rdy = 0; p0_en = 0; p1_en = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_handoff();
    test_simultaneous();
    test_back_to_back();
    test_abandon();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Two-port arbiter that shares the single `spi_sram_master` memory port between the 6502 cache (port 0) and an auxiliary requester (port 1, e.g. boot loader or DMA). It sits between `cache_6502` / the auxiliary master and `spi_sram_master`. It grants whole transactions, including read and write bursts, and never interleaves beats of two requesters. Grant is registered, so the downstream port sees exactly one owner per transaction.

## Interface
Parameters:
- `AW`, 24, memory address width.

Ports (`N` = 0 or 1; each per-port group is replicated as `p0_*` and `p1_*`):
- `clk`  in  1  sole clock.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `pN_addr`  in  AW  requester address.
- `pN_en`  in  1  request; held high until the transaction completes.
- `pN_wr`  in  1  write (1) or read (0).
- `pN_rburst` / `pN_wburst`  in  1  burst continuation flags.
- `pN_wdata`  in  8  write data.
- `pN_rdy`  out  1  `mem_rdy` gated by the port's grant.
- `pN_rdata_load`  out  1  `mem_rdata_load` gated by the port's grant.
- `p_rdata`, `p_rdata0`  out  8  `mem_rdata` and `mem_rdata0` broadcast to both ports.
- `mem_addr`, `mem_en`, `mem_wr`, `mem_rburst`, `mem_wburst`, `mem_wdata`  out  AW/1/1/1/1/8  muxed downstream request.
- `mem_rdy`, `mem_rdata`, `mem_rdata0`, `mem_rdata_load`  in  1/8/8/1  downstream response.
- `gnt`  out  2  one-hot current owner; 00 when idle.

## Operation
- States:
  - `IDLE`: `gnt`=00; all `mem_*` outputs 0.
  - `G0`: port 0 owns the downstream port.
  - `G1`: port 1 owns the downstream port.
- While in `G0`/`G1`:
  - All `mem_*` request outputs are combinationally taken from the owner's inputs.
  - The non-owner sees `pN_rdy` = 0 and `pN_rdata_load` = 0.
- Completion beat = `mem_en & mem_rdy & ~mem_rburst & ~mem_wburst`.
- Burst beats (`rdy` while a burst flag is high) never release the grant.
- Release (`G0`/`G1` -> next state) occurs on either of:
  - the completion beat;
  - the owner dropping `pN_en` (abandon; the owner drops it only after its own `rdy`).
- Next state at release:
  - other port's `en` high -> grant the other port;
  - otherwise -> `IDLE`.
  - The releasing port cannot be re-granted directly; it passes through `IDLE`.
- `IDLE` with both `en` high: winner chosen by the policy (see Configuration).
- `IDLE` with one `en` high: that port is granted.
- `p_rdata` and `p_rdata0` are unqualified; consumers qualify them with their own `pN_rdy` / `pN_rdata_load`.
- Reset (any time, including mid-burst):
  - state -> `IDLE`, `gnt`=00, all outputs 0, priority pointer -> port 0;
  - an in-flight transaction is dropped (`spi_sram_master` shares the reset).

## Timing
- Grant latency: `pN_en` rising in `IDLE` at edge k -> `gnt` and `mem_en` high after edge k+1.
- Handoff: completion at edge k -> other port's `mem_en` high after edge k+1, with no idle cycle.
- Same-port back-to-back transactions: one `IDLE` cycle between them.
- No combinational path from `mem_rdy` to `mem_en`; `gnt` comes from a flop.
- `pN_rdy` follows `mem_rdy` combinationally, with zero added latency.

## Configuration
- `SPI_MEM_ARB_RR_EN` defined (round-robin):
  - a 1-bit pointer flips to favour the non-owner at each release;
  - a simultaneous request in `IDLE` goes to the pointer's port.
- Not defined (fixed priority):
  - port 0 always wins a simultaneous request in `IDLE`;
  - the pointer flop is absent.
- The handoff rule in Operation applies in both modes.

## Test plan
- Reset, no requests -> `gnt`=00, `mem_en`=0, `p0_rdy`=`p1_rdy`=0.
- Port 0 single read at 0x000123; `mem_rdy` pulse with `mem_rdata`=0xA5 -> `p0_rdy`=1, `p_rdata`=0xA5, `p1_rdy`=0, then `gnt`=00.
- Port 1 write burst of 4 beats at 0x010000, with port 0 requesting after beat 1 -> port 0 not granted until the edge after the 4th (non-burst) `rdy`; `mem_addr` switches to `p0_addr` after that edge.
- Both ports request in `IDLE`, repeated 4 times:
  - RR build: grants alternate 0,1,0,1;
  - fixed build: port 0 is granted all 4 times while `p0_en` is held continuously.
- Assert `arst_n`=0 mid-burst in `G1` -> `gnt`=00 and `mem_en`=0 immediately (asynchronously); after release the first simultaneous request is granted to port 0.
